decode_ctrl_pipe: RTL and testbench

//  Decode-stage control unit with the D->E pipeline register. Decodes RV32I lw/sw/R-ALU/I-ALU/beq/jal

---
 rtl/rv_ctrl_pkg.sv | 71 +++++++
 rtl/ctrl_decode_comb.sv | 100 ++++++++++
 rtl/decode_ctrl_pipe.sv | 121 ++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - opcodes, ALU encodings and the decoded control bundle
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic       reg_we;
    logic       src_b;
    logic       dmem_we;
    result_e    result;
    imm_src_e   imm_src;
    logic       branch;
    logic       jump;
    logic [2:0] alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '{
    reg_we:  1'b0,
    src_b:   1'b0,
    dmem_we: 1'b0,
    result:  RES_ALU,
    imm_src: IMM_I,
    branch:  1'b0,
    jump:    1'b0,
    alu_op:  ALU_AND
  };

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // sub_sel only matters for funct3=000; I-type callers pass 0 so it is always add.
  function automatic logic [2:0] alu_from_f3(input logic [2:0] f3, input logic sub_sel);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - combinational RV32I subset decoder: instr -> control bundle
module ctrl_decode_comb
  import rv_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic [4:0]   rd,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic         uses_rs1,
  output logic         uses_rs2
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Illegal encodings leave ctrl at NOP and rd at 0 so they can never write or cause a hazard.
  always_comb begin
    ctrl     = CTRL_NOP;
    illegal  = 1'b0;
    rd       = 5'd0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LW: begin
        if (funct3 == 3'b010) begin
          ctrl.reg_we  = 1'b1;
          ctrl.src_b   = 1'b1;
          ctrl.result  = RES_MEM;
          ctrl.imm_src = IMM_I;
          ctrl.alu_op  = ALU_ADD;
          rd           = instr[11:7];
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_SW: begin
        uses_rs2 = 1'b1;
        if (funct3 == 3'b010) begin
          ctrl.dmem_we = 1'b1;
          ctrl.src_b   = 1'b1;
          ctrl.imm_src = IMM_S;
          ctrl.alu_op  = ALU_ADD;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_R: begin
        uses_rs2 = 1'b1;
        if (((funct7 == F7_BASE) || (funct7 == F7_ALT)) && alu_f3_ok(funct3)) begin
          ctrl.reg_we = 1'b1;
          ctrl.result = RES_ALU;
          ctrl.alu_op = alu_from_f3(funct3, funct7[5]);
          rd          = instr[11:7];
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_I: begin
        if (alu_f3_ok(funct3)) begin
          ctrl.reg_we  = 1'b1;
          ctrl.src_b   = 1'b1;
          ctrl.imm_src = IMM_I;
          ctrl.alu_op  = alu_from_f3(funct3, 1'b0);
          rd           = instr[11:7];
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_BEQ: begin
        uses_rs2 = 1'b1;
        if (funct3 == 3'b000) begin
          ctrl.branch  = 1'b1;
          ctrl.imm_src = IMM_B;
          ctrl.alu_op  = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        uses_rs1     = 1'b0;
        ctrl.reg_we  = 1'b1;
        ctrl.jump    = 1'b1;
        ctrl.result  = RES_PC4;
        ctrl.imm_src = IMM_J;
        rd           = instr[11:7];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - decode control with D->E register, load-use stall, flush, illegal counter
module decode_ctrl_pipe
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr_D,
  input  logic                valid_D,
  output logic                ready_D,
  input  logic                ready_E,
  input  logic                flush_E,
  output logic                valid_E,
  output logic                ctrl_register_file_WE_E,
  output logic                ctrl_srcB_E,
  output logic                ctrl_data_memory_WE_E,
  output logic [1:0]          ctrl_result_E,
  output logic [1:0]          ctrl_imm_src_E,
  output logic                ctrl_branch_E,
  output logic                ctrl_jump_E,
  output logic [ALU_OP_W-1:0] ctrl_ALU_op_E,
  output logic [4:0]          rd_E,
  output logic                illegal_E,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_bundle_t dec_ctrl;
  logic         dec_illegal;
  logic [4:0]   dec_rd;
  logic [4:0]   rs1_D;
  logic [4:0]   rs2_D;
  logic         dec_uses_rs1;
  logic         dec_uses_rs2;

  ctrl_decode_comb u_decode (
    .instr    (instr_D),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .rd       (dec_rd),
    .rs1      (rs1_D),
    .rs2      (rs2_D),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  logic             valid_q,   valid_d;
  ctrl_bundle_t     ctrl_q,    ctrl_d;
  logic [4:0]       rd_q,      rd_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic e_is_load;
  logic load_use;
  logic e_free;
  logic capture;

  // Only lw selects the memory result, so result==MEM identifies a load in E.
  assign e_is_load = valid_q & (ctrl_q.result == RES_MEM);
  assign load_use  = e_is_load & (rd_q != 5'd0) &
                     ((dec_uses_rs1 & (rd_q == rs1_D)) | (dec_uses_rs2 & (rd_q == rs2_D)));
  assign e_free    = ~valid_q | ready_E;
  assign ready_D   = flush_E | (e_free & ~load_use);
  assign capture   = valid_D & ready_D & ~flush_E;

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rd_d      = rd_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush_E || (e_free && !capture)) begin
      valid_d   = 1'b0;
      ctrl_d    = CTRL_NOP;
      rd_d      = 5'd0;
      illegal_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      rd_d      = dec_rd;
      illegal_d = dec_illegal;
    end
    if (capture && dec_illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_E                 = valid_q;
  assign ctrl_register_file_WE_E = ctrl_q.reg_we;
  assign ctrl_srcB_E             = ctrl_q.src_b;
  assign ctrl_data_memory_WE_E   = ctrl_q.dmem_we;
  assign ctrl_result_E           = ctrl_q.result;
  assign ctrl_imm_src_E          = ctrl_q.imm_src;
  assign ctrl_branch_E           = ctrl_q.branch;
  assign ctrl_jump_E             = ctrl_q.jump;
  assign ctrl_ALU_op_E           = ALU_OP_W'(ctrl_q.alu_op);
  assign rd_E                    = rd_q;
  assign illegal_E               = illegal_q;
  assign illegal_cnt             = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb/tb_decode_ctrl_pipe.sv - scoreboard bench for decode_ctrl_pipe
module tb_decode_ctrl_pipe;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_D;
  logic        valid_D, ready_D, ready_E, flush_E, valid_E;
  logic        we_E, srcb_E, dwe_E, br_E, jmp_E, rd_ill_E;
  logic [1:0]  res_E, imm_E;
  logic [2:0]  alu_E;
  logic [4:0]  rd_E;
  logic [7:0]  cnt_E;

  logic [31:0] s_instr;
  logic        s_valid, s_ready_D, s_ready_E, s_flush, s_valid_E;
  logic        s_we, s_srcb, s_dwe, s_br, s_jmp, s_ill;
  logic [1:0]  s_res, s_imm;
  logic [2:0]  s_alu;
  logic [4:0]  s_rd;
  logic [1:0]  s_cnt;

  decode_ctrl_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .instr_D(instr_D), .valid_D(valid_D), .ready_D(ready_D),
    .ready_E(ready_E), .flush_E(flush_E), .valid_E(valid_E),
    .ctrl_register_file_WE_E(we_E), .ctrl_srcB_E(srcb_E), .ctrl_data_memory_WE_E(dwe_E),
    .ctrl_result_E(res_E), .ctrl_imm_src_E(imm_E), .ctrl_branch_E(br_E), .ctrl_jump_E(jmp_E),
    .ctrl_ALU_op_E(alu_E), .rd_E(rd_E), .illegal_E(rd_ill_E), .illegal_cnt(cnt_E)
  );

  decode_ctrl_pipe #(.ALU_OP_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .instr_D(s_instr), .valid_D(s_valid), .ready_D(s_ready_D),
    .ready_E(s_ready_E), .flush_E(s_flush), .valid_E(s_valid_E),
    .ctrl_register_file_WE_E(s_we), .ctrl_srcB_E(s_srcb), .ctrl_data_memory_WE_E(s_dwe),
    .ctrl_result_E(s_res), .ctrl_imm_src_E(s_imm), .ctrl_branch_E(s_br), .ctrl_jump_E(s_jmp),
    .ctrl_ALU_op_E(s_alu), .rd_E(s_rd), .illegal_E(s_ill), .illegal_cnt(s_cnt)
  );

  typedef struct {
    logic [17:0] e;
    logic [17:0] m;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  localparam logic [17:0] FULL  = 18'h3FFFF;
  localparam logic [17:0] NO_RD = 18'h3FFC1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic we, input logic sb_, input logic dwe,
                                     input logic [1:0] res, input logic [1:0] imm,
                                     input logic br, input logic j, input logic [2:0] alu,
                                     input logic [4:0] rd, input logic ill);
    return {we, sb_, dwe, res, imm, br, j, alu, rd, ill};
  endfunction

  function automatic logic [17:0] got_vec();
    return {we_E, srcb_E, dwe_E, res_E, imm_E, br_E, jmp_E, alu_E, rd_E, rd_ill_E};
  endfunction

  task automatic send(input logic [31:0] ins, input logic [17:0] e, input logic [17:0] m,
                      output int stalls);
    sb_t it;
    stalls = 0;
    @(negedge clk);
    instr_D = ins;
    valid_D = 1'b1;
    #1;
    while (!ready_D && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!ready_D) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      it.e = e;
      it.m = m;
      sb.push_back(it);
    end
    @(posedge clk);
    #1;
    valid_D = 1'b0;
  endtask

  always @(negedge clk) begin
    sb_t it;
    #2;
    if (rst_n && valid_E && ready_E && !flush_E) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        it = sb.pop_front();
        chk("sb_out", {14'd0, got_vec() & it.m}, {14'd0, it.e & it.m});
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [17:0] e_add, e_lw;
  logic [1:0]  sat_exp [5];
  int          st;

  initial begin
    rst_n   = 1'b0;
    instr_D = 32'd0;
    valid_D = 1'b0;
    ready_E = 1'b1;
    flush_E = 1'b0;
    s_instr = 32'd0;
    s_valid = 1'b0;
    s_ready_E = 1'b1;
    s_flush = 1'b0;
    e_add = mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b010, 5'd3, 0);
    e_lw  = mk(1, 1, 0, 2'b01, 2'b00, 0, 0, 3'b010, 5'd5, 0);
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_E}, 32'd0);
    chk("rst_bundle", {14'd0, got_vec()}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_E}, 32'd0);
    chk("rst_ready_D", {31'd0, ready_D}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode coverage through the scoreboard.
    send(32'h002081B3, e_add, FULL, st);
    chk("add_valid", {31'd0, valid_E}, 32'd1);
    send(32'h402081B3, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b110, 5'd3, 0), FULL, st);
    send(32'h0020A233, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b111, 5'd4, 0), FULL, st);
    send(32'h0020E233, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b001, 5'd4, 0), FULL, st);
    send(32'h0020F233, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 5'd4, 0), FULL, st);
    send(32'h00508393, mk(1, 1, 0, 2'b00, 2'b00, 0, 0, 3'b010, 5'd7, 0), FULL, st);
    send(32'h40508393, mk(1, 1, 0, 2'b00, 2'b00, 0, 0, 3'b010, 5'd7, 0), FULL, st);
    send(32'h0020A223, mk(0, 1, 1, 2'b00, 2'b01, 0, 0, 3'b010, 5'd0, 0), FULL, st);
    send(32'h008000EF, mk(1, 0, 0, 2'b10, 2'b11, 0, 1, 3'b000, 5'd1, 0), FULL, st);

    // Illegal encodings and the counter.
    chk("cnt_before", {24'd0, cnt_E}, 32'd0);
    send(32'hFE2081B3, mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 5'd0, 1), NO_RD, st);
    chk("cnt_f7", {24'd0, cnt_E}, 32'd1);
    send(32'hFFFFFFFF, mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 5'd0, 1), FULL, st);
    chk("cnt_opc", {24'd0, cnt_E}, 32'd2);
    send(32'h002091B3, mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 5'd0, 1), NO_RD, st);
    chk("cnt_f3", {24'd0, cnt_E}, 32'd3);

    // Load-use on rs1: one stall, one bubble.
    send(32'h0000A283, e_lw, FULL, st);
    @(negedge clk);
    instr_D = 32'h00228333;
    valid_D = 1'b1;
    #1;
    chk("lu_ready_D", {31'd0, ready_D}, 32'd0);
    @(negedge clk);
    #1;
    chk("bubble_valid", {31'd0, valid_E}, 32'd0);
    chk("bubble_ctrl", {14'd0, got_vec()}, 32'd0);
    chk("lu_ready_after", {31'd0, ready_D}, 32'd1);
    sb.push_back('{e: mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b010, 5'd6, 0), m: FULL});
    @(posedge clk);
    #1;
    valid_D = 1'b0;
    chk("lu_add_valid", {31'd0, valid_E}, 32'd1);

    // Hazard boundaries: rs2 of sw, rs2 field of addi, rd=x0, jal.
    send(32'h0000A283, e_lw, FULL, st);
    send(32'h0050A023, mk(0, 1, 1, 2'b00, 2'b01, 0, 0, 3'b010, 5'd0, 0), FULL, st);
    chk("lu_rs2_stall", st, 32'd1);
    send(32'h0000A283, e_lw, FULL, st);
    send(32'h00500413, mk(1, 1, 0, 2'b00, 2'b00, 0, 0, 3'b010, 5'd8, 0), FULL, st);
    chk("itype_no_stall", st, 32'd0);
    send(32'h0000A003, mk(1, 1, 0, 2'b01, 2'b00, 0, 0, 3'b010, 5'd0, 0), FULL, st);
    send(32'h00200333, mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b010, 5'd6, 0), FULL, st);
    chk("x0_no_stall", st, 32'd0);
    send(32'h0000A283, e_lw, FULL, st);
    send(32'h000280EF, mk(1, 0, 0, 2'b10, 2'b11, 0, 1, 3'b000, 5'd1, 0), FULL, st);
    chk("jal_no_stall", st, 32'd0);

    // Stall with ready_E=0, then flush.
    send(32'h002081B3, e_add, FULL, st);
    ready_E = 1'b0;
    @(negedge clk);
    instr_D = 32'h0020E233;
    valid_D = 1'b1;
    #1;
    chk("hold_ready_D", {31'd0, ready_D}, 32'd0);
    chk("hold_valid", {31'd0, valid_E}, 32'd1);
    chk("hold_bundle1", {14'd0, got_vec()}, {14'd0, e_add});
    @(negedge clk);
    #1;
    chk("hold_bundle2", {14'd0, got_vec()}, {14'd0, e_add});
    flush_E = 1'b1;
    #1;
    chk("flush_ready_D", {31'd0, ready_D}, 32'd1);
    @(posedge clk);
    #1;
    flush_E = 1'b0;
    valid_D = 1'b0;
    void'(sb.pop_back());
    chk("flush_valid", {31'd0, valid_E}, 32'd0);
    chk("flush_bundle", {14'd0, got_vec()}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_flush_valid", {31'd0, valid_E}, 32'd0);
    ready_E = 1'b1;

    // Asynchronous reset while a load stalls in E.
    send(32'h0000A283, e_lw, FULL, st);
    ready_E = 1'b0;
    @(negedge clk);
    #1;
    chk("stall_lw_valid", {31'd0, valid_E}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_E}, 32'd0);
    chk("arst_bundle", {14'd0, got_vec()}, 32'd0);
    chk("arst_cnt", {24'd0, cnt_E}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    ready_E = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", {31'd0, valid_E}, 32'd0);
    send(32'h00208063, mk(0, 0, 0, 2'b00, 2'b10, 1, 0, 3'b110, 5'd0, 0), FULL, st);
    @(negedge clk);
    #3;
    chk("sb_left", sb.size(), 32'd0);

    // Saturation on the 2-bit counter instance.
    s_instr = 32'hFFFFFFFF;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("sat_cnt", {30'd0, s_cnt}, {30'd0, sat_exp[i]});
    end
    chk("sat_illegal", {31'd0, s_ill}, 32'd1);
    s_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
